// File: rtl/stream_demux1to2_4bit.sv
// stream_demux1to2_4bit: routes a 4-bit valid/ready stream to one of two
// buffered output streams, selected per word by in_sel.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data, in_sel      input word and route select (0 -> out0, 1 -> out1)
//   in_valid, in_ready   input handshake; in_ready = !full[in_sel]
//   outK_data/valid      head word of buffer K and its non-empty flag
//   outK_ready           downstream acceptance for channel K
//   outK_cnt             saturating per-channel transfer counters
//                        (present only when DEMUX_STATS_EN is defined)
//
// Parameter DEPTH: entries per output buffer, one of 2, 4, 8 or 16.
// Build option: define DEMUX_STATS_EN to add the transfer counters.

module stream_demux1to2_4bit #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_sel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out0_data,
    output logic       out0_valid,
    input  logic       out0_ready,
    output logic [3:0] out1_data,
    output logic       out1_valid,
`ifdef DEMUX_STATS_EN
    input  logic       out1_ready,
    output logic [7:0] out0_cnt,
    output logic [7:0] out1_cnt
`else
    input  logic       out1_ready
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Per-channel circular buffer state, index 0 = out0, 1 = out1.
    logic [DEPTH-1:0][3:0] mem_q    [2];
    logic [DEPTH-1:0][3:0] mem_d    [2];
    logic [PW-1:0]         wr_ptr_q [2];
    logic [PW-1:0]         wr_ptr_d [2];
    logic [PW-1:0]         rd_ptr_q [2];
    logic [PW-1:0]         rd_ptr_d [2];
    logic [CW-1:0]         count_q  [2];
    logic [CW-1:0]         count_d  [2];

    logic [1:0] full;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] push;
    logic [1:0] pop;

    assign ready = {out1_ready, out0_ready};

    // Handshake qualification. The push is gated only by the selected
    // buffer's registered occupancy, so a full buffer never accepts even
    // if it is popped in the same cycle, and out*_ready never reaches
    // in_ready combinationally.
    always_comb begin
        full     = '0;
        valid    = '0;
        push     = '0;
        pop      = '0;
        for (int k = 0; k < 2; k++) begin
            full[k]  = (count_q[k] == CW'(DEPTH));
            valid[k] = (count_q[k] != '0);
        end
        in_ready = in_sel ? !full[1] : !full[0];
        for (int k = 0; k < 2; k++) begin
            push[k] = in_valid && in_ready && (in_sel == 1'(k));
            pop[k]  = valid[k] && ready[k];
        end
    end

    // Next-state for both buffers. Pointers are PW bits wide so they wrap
    // modulo DEPTH on their own (DEPTH is a power of two).
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mem_d[k]    = mem_q[k];
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            count_d[k]  = count_q[k];
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = in_data;
                wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
            end
            // Push and pop together leave the count unchanged.
            count_d[k] = count_q[k] + CW'(push[k]) - CW'(pop[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mem_q[k]    <= '0;
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mem_q[k]    <= mem_d[k];
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                count_q[k]  <= count_d[k];
            end
        end
    end

    // Head of each buffer straight from storage; storage is cleared on
    // reset, so the data outputs read 0 while the buffers are empty
    // after reset.
    assign out0_valid = valid[0];
    assign out1_valid = valid[1];
    assign out0_data  = mem_q[0][rd_ptr_q[0]];
    assign out1_data  = mem_q[1][rd_ptr_q[1]];

`ifdef DEMUX_STATS_EN
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];

    // Saturating output-transfer counters.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = cnt_q[k];
            if (pop[k] && (cnt_q[k] != 8'hFF)) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign out0_cnt = cnt_q[0];
    assign out1_cnt = cnt_q[1];
`endif

endmodule

// File: tb/tb_stream_demux1to2_4bit.sv
// Bench for stream_demux1to2_4bit: directed vectors, per-channel
// scoreboard queues and a negedge output monitor.

module tb_stream_demux1to2_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX_STATS_EN
    logic [7:0] out0_cnt;
    logic [7:0] out1_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [3:0] exp0 [$];
    logic [3:0] exp1 [$];

    stream_demux1to2_4bit #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
`ifdef DEMUX_STATS_EN
        .out1_ready (out1_ready),
        .out0_cnt   (out0_cnt),
        .out1_cnt   (out1_cnt)
`else
        .out1_ready (out1_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one word: record it as expected on its channel, hold it until
    // in_ready is seen at a negedge, then return just after the accepting
    // edge. in_valid is left high so calls can run back to back.
    task automatic send(input logic [3:0] d, input logic s);
        bit ok;
        ok = 1'b0;
        if (s) exp1.push_back(d);
        else   exp0.push_back(d);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept of %0d", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: a transfer seen at a negedge completes on the next
    // rising edge; its data must match the channel's oldest expected word.
    always @(negedge clk) begin
        logic [3:0] w;
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL out0_extra: got %0d expected none", out0_data);
                end else begin
                    w = exp0.pop_front();
                    check("out0_data", {4'd0, out0_data}, {4'd0, w});
                end
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL out1_extra: got %0d expected none", out1_data);
                end else begin
                    w = exp1.pop_front();
                    check("out1_data", {4'd0, out1_data}, {4'd0, w});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        in_data    = 4'd0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #1 rst_n = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_v0", {7'd0, out0_valid}, 8'd0);
        check("rst_v1", {7'd0, out1_valid}, 8'd0);
        check("rst_d0", {4'd0, out0_data}, 8'd0);
        check("rst_d1", {4'd0, out1_data}, 8'd0);
        check("rst_rdy", {7'd0, in_ready}, 8'd1);
`ifdef DEMUX_STATS_EN
        check("rst_c0", out0_cnt, 8'd0);
        check("rst_c1", out1_cnt, 8'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Alternating routing, both outputs ready, 1-cycle latency.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(4'd1, 1'b0);
        check("lat_v0", {7'd0, out0_valid}, 8'd1);
        check("lat_d0", {4'd0, out0_data}, 8'd1);
        send(4'd2, 1'b1);
        check("lat_v1", {7'd0, out1_valid}, 8'd1);
        check("lat_d1", {4'd0, out1_data}, 8'd2);
        send(4'd3, 1'b0);
        send(4'd4, 1'b1);
        idle(3);

        // Back-pressure on out0: third word stalls until drained.
        out0_ready = 1'b0;
        send(4'd5, 1'b0);
        send(4'd6, 1'b0);
        in_data  = 4'd7;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_rdy", {7'd0, in_ready}, 8'd0);
            check("full_head", {4'd0, out0_data}, 8'd5);
        end
        @(posedge clk);
        #1 out0_ready = 1'b1;
        // Pop pending this cycle, but a full buffer still refuses the push.
        @(negedge clk);
        check("no_passthru", {7'd0, in_ready}, 8'd0);
        send(4'd7, 1'b0);
        idle(4);

        // out0 full and stalled must not block out1.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(4'd8, 1'b0);
        send(4'd9, 1'b0);
        in_data  = 4'd12;
        in_sel   = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("x_rdy", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b0;
        exp1.push_back(4'd12);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("x_v1", {7'd0, out1_valid}, 8'd1);
        check("x_d1", {4'd0, out1_data}, 8'd12);
        check("x_v0", {7'd0, out0_valid}, 8'd1);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idle(4);

        // Steady push+pop on out1 with one word resident; pointers wrap.
        out1_ready = 1'b0;
        send(4'd0, 1'b1);
        out1_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            send(4'(i), 1'b1);
            check("wrap_v1", {7'd0, out1_valid}, 8'd1);
            check("wrap_rdy", {7'd0, in_ready}, 8'd1);
        end
        idle(4);

        // Asynchronous reset with both buffers partially full.
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(4'd10, 1'b0);
        send(4'd11, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_v0", {7'd0, out0_valid}, 8'd0);
        check("arst_v1", {7'd0, out1_valid}, 8'd0);
        check("arst_d0", {4'd0, out0_data}, 8'd0);
        check("arst_d1", {4'd0, out1_data}, 8'd0);
        check("arst_rdy", {7'd0, in_ready}, 8'd1);
        exp0.delete();
        exp1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(4'd13, 1'b0);
        check("post_v0", {7'd0, out0_valid}, 8'd1);
        check("post_d0", {4'd0, out0_data}, 8'd13);
        check("post_v1", {7'd0, out1_valid}, 8'd0);
        send(4'd14, 1'b0);
        in_data  = 4'd15;
        in_valid = 1'b1;
        @(negedge clk);
        check("post_full", {7'd0, in_ready}, 8'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out0_ready = 1'b1;
        idle(4);

        // 300 transfers on out0 (2 already done since reset).
        for (int i = 0; i < 300; i++) begin
            send(4'(i), 1'b0);
        end
        idle(4);
`ifdef DEMUX_STATS_EN
        check("cnt0_sat", out0_cnt, 8'd255);
        check("cnt1", out1_cnt, 8'd0);
`endif

        check("q0_empty", 8'(exp0.size()), 8'd0);
        check("q1_empty", 8'(exp1.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
